instr_sequencer: RTL
====================

# instr_sequencer

Multi-cycle fetch/decode/execute sequencer for the MiniMicro core. It owns the program counter and instruction register, and walks each instruction through FETCH → DECODE → EXEC → MEM → WB. It drives the ALU opcode and the register-file and data-memory write strobes with per-state timing, and resolves J, BEQ and HLT. It sits between program memory, the ALU, the register file and data memory, and replaces purely combinational decode with cycle-exact sequencing.

## Interface
- `WORD_SIZE`, default 32: instruction width.
- `OPCODE_SIZE`, default 5: opcode field width, taken from `ir[31:27]`.
- `ADDR_SIZE`, default 9: PC width and jump-target width, taken from `ir[8:0]`.
- `MUL_CYCLES`, default 3: EXEC length for MULS; legal range 1–15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `start` in 1: level; leaves IDLE when high.
- `instr_in` in WORD_SIZE: program-memory read data. Synchronous ROM with 1-cycle latency.
- `flags` in 4: ALU flags `{N,Z,C,V}`; Z is `flags[2]`.
- `mem_ready` in 1: data memory accepted or completed the access.
- `pc` out ADDR_SIZE: program-memory address.
- `ir` out WORD_SIZE: latched instruction.
- `alu_ctrl` out OPCODE_SIZE: ALU opcode.
- `mem_write` out 1: data-memory write strobe.
- `mem_to_reg` out 1: register write-back source is memory.
- `reg_write` out 1: register-file write strobe.
- `retire` out 1: one-cycle pulse on an instruction's final cycle.
- `halted` out 1: high in HALT.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE → FETCH when `start` = 1; otherwise stay in IDLE.
- FETCH: present `pc`.
- DECODE: `ir` ← `instr_in` at the cycle's end.
- Opcode classes:
  - ALU, 1–17: FETCH, DECODE, EXEC, WB.
  - CMP, 18: FETCH, DECODE, EXEC. Flags only, no WB.
  - LOAD, 19: FETCH, DECODE, EXEC, MEM, WB.
  - STORE, 20: FETCH, DECODE, EXEC, MEM.
  - MOV, 21: FETCH, DECODE, EXEC, WB.
  - J, 22 / BEQ, 23: FETCH, DECODE, EXEC.
  - HLT, 24: DECODE → HALT. PC is unchanged.
  - 0 and 25–31: NOP. FETCH, DECODE, EXEC.
- `alu_ctrl` = opcode during EXEC for opcodes 1–18; 0 otherwise.
- Internal Z flag:
  - Z ← `flags[2]` on the last EXEC cycle of opcodes 1–18.
  - Other instructions leave Z unchanged.
  - Reset clears Z.
- PC update, on the last cycle of each instruction:
  - J: `pc` ← `ir[8:0]`.
  - BEQ: `pc` ← `ir[8:0]` if Z, else `pc`+1.
  - All other instructions: `pc`+1.
  - Increment is modulo 2^ADDR_SIZE, so 511 wraps to 0.
- After the last cycle of any instruction except HLT, next state is FETCH.
- MEM:
  - `mem_write` = 1 for STORE.
  - `mem_to_reg` = 1 for LOAD.
  - Hold MEM while `mem_ready` = 0; exit on the first cycle with `mem_ready` = 1.
- WB: `reg_write` = 1. `mem_to_reg` = 1 only for LOAD.
- HALT is exited only by `rst`. `start` is ignored in HALT.
- All strobes are Moore outputs, decoded from the state register and `ir`.

## Timing
- Reset values, effective on the first edge with `rst` = 1:
  - state IDLE.
  - `pc` = 0, `ir` = 0, Z = 0.
  - `alu_ctrl` = 0, `mem_write` = 0, `mem_to_reg` = 0, `reg_write` = 0, `retire` = 0, `halted` = 0.
- `rst` overrides everything, including an in-flight MEM wait or an active WB. No write strobe is asserted in the cycle after the reset edge.
- Latency with `mem_ready` tied high:
  - ALU/MOV: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - J/BEQ/CMP/NOP: 3 cycles.
  - MULS: 3 + MUL_CYCLES cycles (with the macro below).
- `retire` is high during the final state cycle:
  - WB, MEM or EXEC, depending on class.
  - For a held MEM, only the cycle in which `mem_ready` = 1.
- `start` dropping mid-program has no effect. Only IDLE samples it.

## Configuration
- `INSTR_SEQ_MUL_MULTICYCLE_EN`:
  - Defined: MULS (9) holds EXEC for MUL_CYCLES cycles, counted by an internal counter. `alu_ctrl` = 9 throughout EXEC. Z is sampled only on the final EXEC cycle.
  - Undefined: MULS uses a 1-cycle EXEC like every other ALU op; MUL_CYCLES is ignored.

## Test plan
- Reset, then `start` = 1, with ADDS at address 0 → `alu_ctrl` = 6 on cycle 3 only; `reg_write` = 1 on cycle 4 with `retire` = 1; `pc` = 1 on cycle 5.
- LOAD with `mem_ready` low for 2 cycles → MEM lasts 3 cycles with `mem_to_reg` = 1; `reg_write` pulses exactly once, after MEM; total latency 7 cycles.
- SUB with `flags` = 4'b0100, then BEQ with `ir[8:0]` = 9'h0A0 → `pc` = 0x0A0. Repeat with `flags` = 0 → `pc` = previous PC + 1.
- J with target 5 at `pc` = 511, and a NOP at 511 → J lands at 5; NOP wraps `pc` to 0.
- HLT → `halted` = 1 and `pc` frozen for 10 cycles with `start` = 1; then `rst` → IDLE, `pc` = 0.
- With the macro defined and MUL_CYCLES = 3: MULS holds `alu_ctrl` = 9 for 3 cycles, total latency 6. `rst` asserted mid-EXEC → next cycle IDLE, `reg_write` = 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MiniMicro core.
// It owns the program counter and the instruction register. It drives the ALU
// opcode and the register-file and data-memory strobes, and it resolves J,
// BEQ and HLT.
//
// Optional feature macro: INSTR_SEQ_MUL_MULTICYCLE_EN
//   When defined, MULS (opcode 9) holds EXEC for MUL_CYCLES cycles.
//   When undefined, MULS behaves like any other single-cycle ALU op.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   level; sampled only in IDLE
//   instr_in   in   program ROM read data (1-cycle latency from pc)
//   flags      in   ALU flags {N,Z,C,V}
//   mem_ready  in   data memory accepted/completed the access
//   pc         out  program-memory address
//   ir         out  latched instruction
//   alu_ctrl   out  ALU opcode (0 when idle)
//   mem_write  out  data-memory write strobe
//   mem_to_reg out  write-back source is memory
//   reg_write  out  register-file write strobe
//   retire     out  pulse on an instruction's final cycle
//   halted     out  high in HALT
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int WORD_SIZE   = 32,
    parameter int OPCODE_SIZE = 5,
    parameter int ADDR_SIZE   = 9,
    parameter int MUL_CYCLES  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WORD_SIZE-1:0]   instr_in,
    input  logic [3:0]             flags,
    input  logic                   mem_ready,
    output logic [ADDR_SIZE-1:0]   pc,
    output logic [WORD_SIZE-1:0]   ir,
    output logic [OPCODE_SIZE-1:0] alu_ctrl,
    output logic                   mem_write,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   retire,
    output logic                   halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [OPCODE_SIZE-1:0] OP_ALU_LO = OPCODE_SIZE'(1);
    localparam logic [OPCODE_SIZE-1:0] OP_ALU_HI = OPCODE_SIZE'(17);
    localparam logic [OPCODE_SIZE-1:0] OP_CMP    = OPCODE_SIZE'(18);
    localparam logic [OPCODE_SIZE-1:0] OP_LOAD   = OPCODE_SIZE'(19);
    localparam logic [OPCODE_SIZE-1:0] OP_STORE  = OPCODE_SIZE'(20);
    localparam logic [OPCODE_SIZE-1:0] OP_MOV    = OPCODE_SIZE'(21);
    localparam logic [OPCODE_SIZE-1:0] OP_J      = OPCODE_SIZE'(22);
    localparam logic [OPCODE_SIZE-1:0] OP_BEQ    = OPCODE_SIZE'(23);
    localparam logic [OPCODE_SIZE-1:0] OP_HLT    = OPCODE_SIZE'(24);

    state_t state, state_nxt;

    logic [OPCODE_SIZE-1:0] op;      // opcode of the latched instruction
    logic [OPCODE_SIZE-1:0] dec_op;  // opcode on the ROM bus during DECODE
    logic                   zflag;

    assign op     = ir[WORD_SIZE-1 -: OPCODE_SIZE];
    assign dec_op = instr_in[WORD_SIZE-1 -: OPCODE_SIZE];

    logic is_alu, is_flagop, is_load, is_store, is_mov, is_j, is_beq;
    assign is_alu    = (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
    assign is_flagop = (op >= OP_ALU_LO) && (op <= OP_CMP);
    assign is_load   = (op == OP_LOAD);
    assign is_store  = (op == OP_STORE);
    assign is_mov    = (op == OP_MOV);
    assign is_j      = (op == OP_J);
    assign is_beq    = (op == OP_BEQ);

    // Classes that continue past EXEC; everything else retires in EXEC.
    logic needs_wb, needs_mem;
    assign needs_wb  = is_alu || is_mov;
    assign needs_mem = is_load || is_store;

    // exec_last marks the final EXEC cycle. Only MULS can stretch EXEC.
    logic exec_last;

`ifdef INSTR_SEQ_MUL_MULTICYCLE_EN
    localparam logic [OPCODE_SIZE-1:0] OP_MULS = OPCODE_SIZE'(9);
    logic [3:0] mul_cnt;

    assign exec_last = (op != OP_MULS) || (mul_cnt == 4'(MUL_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst)
            mul_cnt <= '0;
        else if (state == S_EXEC && !exec_last)
            mul_cnt <= mul_cnt + 4'd1;
        else
            mul_cnt <= '0;
    end

    logic unused_sig;
    assign unused_sig = ^{flags[3], flags[1:0]};
`else
    assign exec_last = 1'b1;

    logic unused_sig;
    assign unused_sig = ^{flags[3], flags[1:0]} ^ (MUL_CYCLES != 0);
`endif

    // Final cycle of the instruction: drives retire and the PC update.
    logic last_cycle;
    assign last_cycle = (state == S_WB)
                     || (state == S_MEM && mem_ready && !is_load)
                     || (state == S_EXEC && exec_last && !needs_wb && !needs_mem);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            // ir is still the previous instruction here, so HLT is seen on the ROM bus.
            S_DECODE: state_nxt = (dec_op == OP_HLT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (exec_last) begin
                    if (needs_wb)       state_nxt = S_WB;
                    else if (needs_mem) state_nxt = S_MEM;
                    else                state_nxt = S_FETCH;
                end
            end
            S_MEM:    if (mem_ready) state_nxt = is_load ? S_WB : S_FETCH;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs (decoded from state and ir; retire also sees mem_ready in MEM)
    always_comb begin
        alu_ctrl   = '0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;
        retire     = last_cycle;
        case (state)
            S_EXEC: if (is_flagop) alu_ctrl = op;
            S_MEM: begin
                mem_write  = is_store;
                mem_to_reg = is_load;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // PC, IR and the internal Z flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            ir    <= '0;
            zflag <= 1'b0;
        end else begin
            if (state == S_DECODE)
                ir <= instr_in;
            if (state == S_EXEC && exec_last && is_flagop)
                zflag <= flags[2];
            if (last_cycle) begin
                if (is_j || (is_beq && zflag))
                    pc <= ir[ADDR_SIZE-1:0];
                else
                    pc <= pc + ADDR_SIZE'(1);
            end
        end
    end

endmodule
